// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, status bit positions
// and controller state encoding.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_LSL = 3'b101;
  localparam logic [2:0] OP_LSR = 3'b110;
  localparam logic [2:0] OP_ASR = 3'b111;

  localparam int unsigned ST_N = 2;
  localparam int unsigned ST_V = 1;
  localparam int unsigned ST_Z = 0;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, W cycles.
// prod carries the final 2W-bit product combinationally while fin is high.
module mul_iter #(
  parameter int unsigned W = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           go,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           fin,
  output logic [2*W-1:0] prod
);

  localparam int unsigned CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [2*W-1:0] acc_q, acc_d, mcand_q;
  logic [W-1:0]   mplier_q;
  logic [CW-1:0]  cnt_q;
  logic           run_q;

  always_comb begin
    acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
    fin   = run_q && (cnt_q == LAST);
    busy  = run_q;
    prod  = acc_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else if (go && !run_q) begin
      acc_q    <= '0;
      mcand_q  <= {{W{1'b0}}, a};
      mplier_q <= b;
      cnt_q    <= '0;
      run_q    <= 1'b1;
    end else if (run_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (fin) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ADD/SUB/AND/NOT/shifts, iterative MUL, with a
// start/busy/done handshake and registered result and {N,V,Z} status.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] Ain,
  input  logic [W-1:0] Bin,
  output logic [W-1:0] out,
  output logic [2:0]   status,
  output logic         busy,
  output logic         done
);

  localparam int unsigned LW = $clog2(W);

  state_t         state_q, state_d;
  logic [W-1:0]   out_q, out_d;
  logic [2:0]     status_q, status_d;
  logic           done_q, done_d;

  logic [W-1:0]   alu_res;
  logic           alu_v;
  logic [LW-1:0]  shamt;

  logic           mul_go, mul_busy, mul_fin;
  logic [2*W-1:0] mul_prod;

  mul_iter #(
    .W (W)
  ) u_mul (
    .clk   (clk),
    .reset (reset),
    .go    (mul_go),
    .a     (Ain),
    .b     (Bin),
    .busy  (mul_busy),
    .fin   (mul_fin),
    .prod  (mul_prod)
  );

  assign shamt = Bin[LW-1:0];

  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = Ain + Bin;
        alu_v   = (Ain[W-1] == Bin[W-1]) && (alu_res[W-1] != Ain[W-1]);
      end
      OP_SUB: begin
        alu_res = Ain - Bin;
        alu_v   = (Ain[W-1] != Bin[W-1]) && (alu_res[W-1] != Ain[W-1]);
      end
      OP_AND:  alu_res = Ain & Bin;
      OP_NOT:  alu_res = ~Bin;
      OP_LSL:  alu_res = Ain << shamt;
      OP_LSR:  alu_res = Ain >> shamt;
      OP_ASR:  alu_res = W'($signed(Ain) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    status_d = status_q;
    done_d   = 1'b0;
    mul_go   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            mul_go  = 1'b1;
            state_d = MUL;
          end else begin
            out_d          = alu_res;
            status_d[ST_N] = alu_res[W-1];
            status_d[ST_V] = alu_v;
            status_d[ST_Z] = (alu_res == '0);
            done_d         = 1'b1;
          end
        end
      end
      MUL: begin
        if (mul_fin) begin
          out_d          = mul_prod[W-1:0];
          status_d[ST_N] = mul_prod[W-1];
          status_d[ST_V] = |mul_prod[2*W-1:W];
          status_d[ST_Z] = (mul_prod[W-1:0] == '0);
          done_d         = 1'b1;
          state_d        = IDLE;
        end else if (!mul_busy) begin
          // Multiplier lost its run state without finishing; don't wedge.
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      out_q    <= '0;
      status_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      status_q <= status_d;
      done_q   <= done_d;
    end
  end

  assign out    = out_q;
  assign status = status_q;
  assign done   = done_q;
  assign busy   = (state_q == MUL);

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at W=16.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [15:0] Ain, Bin;
  logic [15:0] out;
  logic [2:0]  status;
  logic        busy, done;

  int errors = 0;
  int checks = 0;

  alu_mc #(
    .W (16)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .Ain    (Ain),
    .Bin    (Bin),
    .out    (out),
    .status (status),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Present a request before an edge, sample 1ns after that edge (E0).
  task automatic issue(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    start = 1'b1; op = o; Ain = a; Bin = b;
    @(posedge clk); #1;
    start = 1'b0; Ain = 16'hDEAD; Bin = 16'hBEEF;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 3'b000; Ain = '0; Bin = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out !== 16'h0000) begin errors++; $display("FAIL reset_out got=%h exp=0000", out); end
    checks++; if (status !== 3'b000) begin errors++; $display("FAIL reset_status got=%b exp=000", status); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_add();
    issue(3'b000, 16'h7FFF, 16'h0001);
    checks++; if (out !== 16'h8000) begin errors++; $display("FAIL add_out got=%h exp=8000", out); end
    checks++; if (status !== 3'b110) begin errors++; $display("FAIL add_status got=%b exp=110", status); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL add_done got=%b exp=1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL add_done_drop got=%b exp=0", done); end
    checks++; if (out !== 16'h8000) begin errors++; $display("FAIL add_out_hold got=%h exp=8000", out); end
  endtask

  task automatic test_back_to_back();
    issue(3'b001, 16'h0005, 16'h0005);
    checks++; if (out !== 16'h0000) begin errors++; $display("FAIL sub_out got=%h exp=0000", out); end
    checks++; if (status !== 3'b001) begin errors++; $display("FAIL sub_status got=%b exp=001", status); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL sub_done got=%b exp=1", done); end
    issue(3'b011, 16'h1234, 16'h0000);
    checks++; if (out !== 16'hFFFF) begin errors++; $display("FAIL not_out got=%h exp=FFFF", out); end
    checks++; if (status !== 3'b100) begin errors++; $display("FAIL not_status got=%b exp=100", status); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL not_done got=%b exp=1", done); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_drop got=%b exp=0", done); end
  endtask

  task automatic test_mul(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_out, input logic [2:0] exp_st);
    int n;
    issue(3'b100, a, b);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mul_done_early got=%b exp=0", done); end
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL mul_busy_cycles got=%0d exp=16", n); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mul_done got=%b exp=1", done); end
    checks++; if (out !== exp_out) begin errors++; $display("FAIL mul_out got=%h exp=%h", out, exp_out); end
    checks++; if (status !== exp_st) begin errors++; $display("FAIL mul_status got=%b exp=%b", status, exp_st); end
  endtask

  task automatic test_mul_ignore_start();
    int dones;
    issue(3'b100, 16'h0003, 16'h0007);
    dones = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      start = (i >= 2 && i < 6); op = 3'b000; Ain = 16'h0001; Bin = 16'h0001;
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    start = 1'b0;
    checks++; if (dones !== 1) begin errors++; $display("FAIL mul_ignore_dones got=%0d exp=1", dones); end
    checks++; if (out !== 16'h0015) begin errors++; $display("FAIL mul_ignore_out got=%h exp=0015", out); end
  endtask

  task automatic test_shifts();
    issue(3'b111, 16'h8000, 16'h0004);
    checks++; if (out !== 16'hF800) begin errors++; $display("FAIL asr_out got=%h exp=F800", out); end
    checks++; if (status !== 3'b100) begin errors++; $display("FAIL asr_status got=%b exp=100", status); end
    issue(3'b101, 16'h0001, 16'h0013);
    checks++; if (out !== 16'h0008) begin errors++; $display("FAIL lsl_out got=%h exp=0008", out); end
    checks++; if (status !== 3'b000) begin errors++; $display("FAIL lsl_status got=%b exp=000", status); end
    issue(3'b110, 16'h8000, 16'h000F);
    checks++; if (out !== 16'h0001) begin errors++; $display("FAIL lsr_out got=%h exp=0001", out); end
    issue(3'b010, 16'hF0F0, 16'h0FF0);
    checks++; if (out !== 16'h00F0) begin errors++; $display("FAIL and_out got=%h exp=00F0", out); end
    checks++; if (status !== 3'b000) begin errors++; $display("FAIL and_status got=%b exp=000", status); end
  endtask

  task automatic test_reset_mid_mul();
    int dones;
    issue(3'b100, 16'h0003, 16'h0007);
    repeat (7) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmul_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmul_done got=%b exp=0", done); end
    checks++; if (out !== 16'h0000) begin errors++; $display("FAIL rmul_out got=%h exp=0000", out); end
    checks++; if (status !== 3'b000) begin errors++; $display("FAIL rmul_status got=%b exp=000", status); end
    @(negedge clk); reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL rmul_stale_activity got=%0d exp=0", dones); end
    issue(3'b000, 16'h0002, 16'h0003);
    checks++; if (out !== 16'h0005) begin errors++; $display("FAIL rmul_add_out got=%h exp=0005", out); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL rmul_add_done got=%b exp=1", done); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_mul(16'h0003, 16'h0007, 16'h0015, 3'b000);
    test_mul(16'h0100, 16'h0100, 16'h0000, 3'b011);
    test_mul(16'hFFFF, 16'hFFFF, 16'h0001, 3'b010);
    test_mul_ignore_start();
    test_shifts();
    test_reset_mid_mul();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
